aes_req_arbiter: RTL and testbench
==================================

Name: aes_req_arbiter

Overview:
- Shares one AES-128 encryption engine between N_REQ independent requesters using round-robin arbitration.
- Each requester submits a key and plaintext with a valid/ready handshake and receives its ciphertext with a valid/ready handshake.
- The block drives the engine's valid_in/key/plaintext inputs and consumes its registered cipher_text/valid_out outputs. Engine latency is 1 clk.
- At most one job is in flight at a time.

Parameters:
- N_REQ, 4: number of requesters; must be at least 2.
- DATA_W, 128: plaintext/ciphertext width.
- KEY_L, 128: key width.
- TIMEOUT_CYC, 16: maximum cycles in WAIT before a timeout is declared. TO_W = clog2(TIMEOUT_CYC+1).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous reset, active-low
- req_valid  in  N_REQ  per-requester job valid
- req_ready  out  N_REQ  per-requester accept; one-hot or zero
- req_key  in  N_REQ*KEY_L  packed keys; requester i at [i*KEY_L +: KEY_L]
- req_data  in  N_REQ*DATA_W  packed plaintexts; same packing
- rsp_valid  out  N_REQ  per-requester result valid; one-hot or zero
- rsp_ready  in  N_REQ  per-requester result accept
- rsp_data  out  DATA_W  ciphertext, shared by all requesters; meaningful only where rsp_valid is set
- eng_valid_in  out  1  engine start
- eng_key  out  KEY_L  engine key
- eng_plain  out  DATA_W  engine plaintext
- eng_cipher  in  DATA_W  engine ciphertext
- eng_valid_out  in  1  engine result valid
- busy  out  1  high when state is not IDLE
- err_timeout  out  1  sticky timeout flag
- err_clr  in  1  synchronous clear of err_timeout

Behaviour:
- Reset values: state=IDLE, rr_ptr=0, grant_id=0; eng_valid_in, req_ready, rsp_valid, busy, err_timeout = 0; eng_key, eng_plain, rsp_data = 0.
- Reset asserted mid-job discards the job. No response is issued for it.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If req_valid is nonzero, select the first set bit searching upward from rr_ptr, wrapping modulo N_REQ.
  - Drive req_ready[g]=1 combinationally in that same cycle. The handshake completes.
  - Latch req_key[g], req_data[g] into eng_key/eng_plain and g into grant_id, then go to ISSUE.
  - With no request, stay in IDLE with req_ready=0.
- ISSUE: eng_valid_in=1 for exactly this one cycle, then go to WAIT. eng_key/eng_plain are held stable until the next grant.
- WAIT:
  - A to_cnt counter resets to 0 on entry and increments each cycle.
  - On eng_valid_out=1, capture eng_cipher into rsp_data and go to RESP.
  - If to_cnt reaches TIMEOUT_CYC-1 without eng_valid_out, set err_timeout, set rr_ptr=(grant_id+1) mod N_REQ, go to IDLE, and issue no response.
- RESP:
  - rsp_valid[grant_id]=1 (registered); rsp_data is held stable.
  - When rsp_ready[grant_id]=1, the response completes. Set rr_ptr=(grant_id+1) mod N_REQ and go to IDLE.
  - rsp_ready on other bits is ignored.
- eng_valid_out outside WAIT is ignored and does not alter rsp_data.
- Nominal timing with an immediate rsp_ready:
  - accept (IDLE) at cycle t, eng_valid_in at t+1, eng_valid_out at t+2 (WAIT), rsp_valid at t+3.
  - Minimum job period is 4 cycles.
- Fairness: a continuously requesting requester waits at most N_REQ-1 jobs.
- Simultaneous err_clr and timeout set: set wins.
- req_valid dropping before grant is legal; no job is created.
- req_key/req_data are sampled only in the accept cycle.

Test Plan:
- Single job:
  - Stimulus: requester 2 with key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff, engine model attached, rsp_ready held 1.
  - Required response: req_ready[2] at t, eng_valid_in at t+1, rsp_valid=4'b0100 at t+3, rsp_data=69c4e0d86a7b0430d8cdb78070b4c55a.
- Round robin:
  - Stimulus: all four req_valid held high, rsp_ready=1.
  - Required response: grant order 0,1,2,3,0; each job takes 4 cycles.
- Backpressure:
  - Stimulus: rsp_ready[1] held low for 5 cycles after rsp_valid[1] rises.
  - Required response: rsp_valid[1] and rsp_data stay stable, req_ready stays 0, and the next grant occurs only after the rsp_ready handshake.
- Timeout:
  - Stimulus: engine model suppresses eng_valid_out on a job from requester 3.
  - Required response: err_timeout rises 16 cycles after WAIT entry, no rsp_valid is asserted, the FSM returns to IDLE, and the next grant starts search at 0. err_clr=1 then clears the flag.
- Reset mid-job:
  - Stimulus: reset_n pulsed low during WAIT.
  - Required response: all outputs return to their reset values immediately, a late eng_valid_out is ignored, and the first grant after reset goes to the lowest valid requester.
- Stray engine valid:
  - Stimulus: eng_valid_out pulsed while in IDLE.
  - Required response: no rsp_valid and rsp_data unchanged.

Source files
------------

// File: rtl/aes_req_arbiter.sv
// Round-robin arbiter sharing one AES-128 engine between N_REQ requesters.
// One job in flight at a time, with per-requester valid/ready on the job and response sides.
module aes_req_arbiter #(
    parameter int unsigned N_REQ       = 4,
    parameter int unsigned DATA_W      = 128,
    parameter int unsigned KEY_L       = 128,
    parameter int unsigned TIMEOUT_CYC = 16,
    localparam int unsigned TO_W       = $clog2(TIMEOUT_CYC + 1),
    localparam int unsigned ID_W       = $clog2(N_REQ)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [N_REQ-1:0]        req_valid,
    output logic [N_REQ-1:0]        req_ready,
    input  logic [N_REQ*KEY_L-1:0]  req_key,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        rsp_valid,
    input  logic [N_REQ-1:0]        rsp_ready,
    output logic [DATA_W-1:0]       rsp_data,
    output logic                    eng_valid_in,
    output logic [KEY_L-1:0]        eng_key,
    output logic [DATA_W-1:0]       eng_plain,
    input  logic [DATA_W-1:0]       eng_cipher,
    input  logic                    eng_valid_out,
    output logic                    busy,
    output logic                    err_timeout,
    input  logic                    err_clr
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e            state_q, state_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]   grant_id_q, grant_id_d;
    logic [ID_W-1:0]   grant_idx, cand, id_next;
    logic              grant_found;
    logic              timeout_hit;
    logic [KEY_L-1:0]  key_q, key_d;
    logic [DATA_W-1:0] plain_q, plain_d;
    logic [DATA_W-1:0] rsp_q, rsp_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic              err_q, err_d;

    // First requesting index at or above rr_ptr, wrapping.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < int'(N_REQ); k++) begin
            cand = ID_W'((int'(rr_ptr_q) + k) % int'(N_REQ));
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign id_next = (grant_id_q == ID_W'(N_REQ - 1)) ? '0 : grant_id_q + ID_W'(1);

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        grant_id_d   = grant_id_q;
        key_d        = key_q;
        plain_d      = plain_q;
        rsp_d        = rsp_q;
        to_cnt_d     = to_cnt_q;
        req_ready    = '0;
        rsp_valid    = '0;
        eng_valid_in = 1'b0;
        timeout_hit  = 1'b0;

        case (state_q)
            StIdle: begin
                if (grant_found) begin
                    req_ready[grant_idx] = 1'b1;
                    key_d      = req_key[grant_idx*KEY_L +: KEY_L];
                    plain_d    = req_data[grant_idx*DATA_W +: DATA_W];
                    grant_id_d = grant_idx;
                    state_d    = StIssue;
                end
            end
            StIssue: begin
                eng_valid_in = 1'b1;
                to_cnt_d     = '0;
                state_d      = StWait;
            end
            StWait: begin
                if (eng_valid_out) begin
                    rsp_d   = eng_cipher;
                    state_d = StResp;
                end else if (to_cnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
                    // Abandon the job silently; the requester sees no response.
                    timeout_hit = 1'b1;
                    rr_ptr_d    = id_next;
                    state_d     = StIdle;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            StResp: begin
                rsp_valid[grant_id_q] = 1'b1;
                if (rsp_ready[grant_id_q]) begin
                    rr_ptr_d = id_next;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // A timeout in the same cycle as err_clr leaves the flag set.
        if (timeout_hit) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            rr_ptr_q   <= '0;
            grant_id_q <= '0;
            key_q      <= '0;
            plain_q    <= '0;
            rsp_q      <= '0;
            to_cnt_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_id_q <= grant_id_d;
            key_q      <= key_d;
            plain_q    <= plain_d;
            rsp_q      <= rsp_d;
            to_cnt_q   <= to_cnt_d;
            err_q      <= err_d;
        end
    end

    assign eng_key     = key_q;
    assign eng_plain   = plain_q;
    assign rsp_data    = rsp_q;
    assign busy        = (state_q != StIdle);
    assign err_timeout = err_q;

endmodule

// File: tb/tb_aes_req_arbiter.sv
// Bench for aes_req_arbiter: job-level reference model checked every cycle plus directed
// scenarios with hand-computed timing and data expectations.
module tb_aes_req_arbiter;

    localparam int N  = 4;
    localparam int DW = 128;
    localparam int KL = 128;
    localparam int TO = 16;

    localparam logic [127:0] K_FIPS = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P_FIPS = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C_FIPS = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [N-1:0]  req_valid = '0;
    logic [N-1:0]  req_ready;
    logic [N*KL-1:0] req_key = '0;
    logic [N*DW-1:0] req_data = '0;
    logic [N-1:0]  rsp_valid;
    logic [N-1:0]  rsp_ready = '0;
    logic [DW-1:0] rsp_data;
    logic          eng_valid_in;
    logic [KL-1:0] eng_key;
    logic [DW-1:0] eng_plain;
    logic [DW-1:0] eng_cipher;
    logic          eng_valid_out;
    logic          busy;
    logic          err_timeout;
    logic          err_clr = 1'b0;

    aes_req_arbiter dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_key      (req_key),
        .req_data     (req_data),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .eng_valid_in (eng_valid_in),
        .eng_key      (eng_key),
        .eng_plain    (eng_plain),
        .eng_cipher   (eng_cipher),
        .eng_valid_out(eng_valid_out),
        .busy         (busy),
        .err_timeout  (err_timeout),
        .err_clr      (err_clr)
    );

    always #5 clk = ~clk;

    // Engine stand-in: the arbiter is data-agnostic, so only the FIPS-197 vector is real AES.
    function automatic logic [127:0] fake_enc(input logic [127:0] k, input logic [127:0] p);
        if (k == K_FIPS && p == P_FIPS) return C_FIPS;
        return k ^ {p[63:0], p[127:64]} ^ 128'hc3c3_5a5a_0f0f_a5a5_3c3c_9696_f0f0_1234;
    endfunction

    logic          eng_suppress = 1'b0;
    logic          stray = 1'b0;
    logic [DW-1:0] stray_ct = '0;
    logic          eng_vo_q = 1'b0;
    logic [DW-1:0] eng_ct_q = '0;

    always @(posedge clk) begin
        eng_vo_q <= eng_valid_in && !eng_suppress;
        eng_ct_q <= fake_enc(eng_key, eng_plain);
    end
    assign eng_valid_out = eng_vo_q | stray;
    assign eng_cipher    = stray ? stray_ct : eng_ct_q;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // Reference model: job in flight, cycles since accept, pending response.
    bit            m_job, m_have, m_err, to_fire;
    int            m_age, m_gid, m_ptr, g;
    logic [KL-1:0] m_key;
    logic [DW-1:0] m_pt, m_ct;
    logic [N-1:0]  e_rdy, e_rv;
    logic          e_evi;

    function automatic int pick(input logic [N-1:0] v, input int ptr);
        for (int k = 0; k < N; k++) if (v[(ptr + k) % N]) return (ptr + k) % N;
        return -1;
    endfunction

    always @(negedge clk) begin
        e_rdy = '0; e_rv = '0; e_evi = 1'b0; to_fire = 1'b0; g = -1;
        if (!reset_n) begin
            m_job = 0; m_have = 0; m_err = 0; m_age = 0; m_gid = 0; m_ptr = 0;
            m_key = '0; m_pt = '0; m_ct = '0;
        end else begin
            if (!m_job) begin
                g = pick(req_valid, m_ptr);
                if (g >= 0) e_rdy[g] = 1'b1;
            end else if (m_age == 1) begin
                e_evi = 1'b1;
            end
            if (m_have) e_rv[m_gid] = 1'b1;
        end
        chk("req_ready", req_ready, e_rdy);
        chk("rsp_valid", rsp_valid, e_rv);
        chk("eng_valid_in", eng_valid_in, e_evi);
        chk("busy", busy, m_job);
        chk("err_timeout", err_timeout, m_err);
        chk("rsp_data", rsp_data, m_ct);
        chk("eng_key", eng_key, m_key);
        chk("eng_plain", eng_plain, m_pt);
        if (reset_n) begin
            if (!m_job) begin
                if (g >= 0) begin
                    m_job = 1; m_age = 1; m_gid = g;
                    m_key = req_key[g*KL +: KL];
                    m_pt  = req_data[g*DW +: DW];
                end
            end else if (m_have) begin
                if (rsp_ready[m_gid]) begin
                    m_job = 0; m_have = 0; m_ptr = (m_gid + 1) % N;
                end
            end else if (m_age >= 2 && eng_valid_out) begin
                m_have = 1; m_ct = eng_cipher; m_age++;
            end else if (m_age - 2 == TO - 1) begin
                to_fire = 1; m_job = 0; m_ptr = (m_gid + 1) % N;
            end else begin
                m_age++;
            end
            if (to_fire) m_err = 1;
            else if (err_clr) m_err = 0;
        end
    end

    // Event log for the directed timing checks.
    int           grants[$];
    int           gcyc[$];
    int           t_evi, t_rsp, t_err, rsp_seen;
    logic [N-1:0] rsp_vec, rv_prev;
    logic [DW-1:0] rsp_cap;
    logic         err_prev;

    always @(negedge clk) begin
        if (!reset_n) begin
            rv_prev  = '0;
            err_prev = 1'b0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (req_ready[i]) begin
                    grants.push_back(i);
                    gcyc.push_back(cyc);
                end
            end
            if (eng_valid_in) t_evi = cyc;
            if (rsp_valid != '0 && rv_prev == '0) begin
                t_rsp = cyc; rsp_vec = rsp_valid; rsp_cap = rsp_data; rsp_seen++;
            end
            if (err_timeout && !err_prev) t_err = cyc;
            rv_prev  = rsp_valid;
            err_prev = err_timeout;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        @(negedge clk);
        while (busy && n < 80) begin
            @(negedge clk);
            n++;
        end
        chk(name, busy, 1'b0);
        tick();
    endtask

    task automatic run_job(input int r, input logic [127:0] k, input logic [127:0] p);
        int n = 0;
        req_key[r*KL +: KL]  = k;
        req_data[r*DW +: DW] = p;
        req_valid[r]         = 1'b1;
        @(negedge clk);
        while (!req_ready[r] && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("accept", req_ready[r], 1'b1);
        tick();
        req_valid[r] = 1'b0;
        // Inputs after the accept cycle must not reach the engine.
        req_key[r*KL +: KL]  = ~k;
        req_data[r*DW +: DW] = ~p;
    endtask

    int            n, hs_cyc, seen0;
    logic [127:0]  k1, p1;

    initial begin
        t_evi = 0; t_rsp = 0; t_err = 0; rsp_seen = 0;
        repeat (3) tick();
        @(negedge clk);
        chk("reset_busy", busy, 1'b0);
        chk("reset_rsp_data", rsp_data, '0);
        chk("reset_eng_key", eng_key, '0);
        tick();
        reset_n = 1'b1;
        tick();

        // Round robin with every requester asking and an always-ready consumer.
        rsp_ready = '1;
        for (int i = 0; i < N; i++) begin
            req_key[i*KL +: KL]  = 128'h1000 + 128'(i);
            req_data[i*DW +: DW] = 128'hab00 + 128'(i);
        end
        grants.delete(); gcyc.delete();
        req_valid = '1;
        n = 0;
        while (grants.size() < 5 && n < 60) begin
            @(negedge clk);
            n++;
        end
        tick();
        req_valid = '0;
        wait_idle("rr_idle");
        chk("rr_count", grants.size(), 5);
        if (grants.size() >= 5) begin
            chk("rr_g0", grants[0], 0);
            chk("rr_g1", grants[1], 1);
            chk("rr_g2", grants[2], 2);
            chk("rr_g3", grants[3], 3);
            chk("rr_g4", grants[4], 0);
            for (int i = 0; i < 4; i++) chk("rr_period", gcyc[i+1] - gcyc[i], 4);
        end

        // Single job on requester 2 with the FIPS-197 vector.
        grants.delete(); gcyc.delete();
        run_job(2, K_FIPS, P_FIPS);
        wait_idle("single_idle");
        chk("single_grant", (grants.size() > 0) ? grants[$] : -1, 2);
        chk("single_evi_lat", t_evi - gcyc[$], 1);
        chk("single_rsp_lat", t_rsp - gcyc[$], 3);
        chk("single_rsp_vec", rsp_vec, 4'b0100);
        chk("single_rsp_data", rsp_cap, C_FIPS);

        // Stray engine valid while idle.
        stray_ct = 128'hdead_beef_0000_1111_2222_3333_4444_5555;
        stray    = 1'b1;
        tick();
        stray    = 1'b0;
        @(negedge clk);
        chk("stray_rsp_valid", rsp_valid, '0);
        chk("stray_rsp_data", rsp_data, C_FIPS);
        tick();

        // Backpressure on requester 1 for 5 cycles.
        k1 = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
        p1 = 128'h5555_aaaa_5555_aaaa_0f0f_f0f0_1234_5678;
        rsp_ready = 4'b1101;
        run_job(1, k1, p1);
        n = 0;
        @(negedge clk);
        while (rsp_valid == '0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("bp_rsp_valid", rsp_valid, 4'b0010);
        chk("bp_rsp_data", rsp_data, fake_enc(k1, p1));
        for (int i = 1; i < 5; i++) begin
            tick();
            req_valid[0] = 1'b1;
            @(negedge clk);
            chk("bp_hold_valid", rsp_valid, 4'b0010);
            chk("bp_hold_data", rsp_data, fake_enc(k1, p1));
            chk("bp_no_grant", req_ready, '0);
        end
        tick();
        rsp_ready = '1;
        hs_cyc = cyc;
        n = 0;
        @(negedge clk);
        while (!req_ready[0] && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("bp_next_grant_cyc", cyc - hs_cyc, 1);
        tick();
        req_valid = '0;
        wait_idle("bp_idle");

        // Timeout on requester 3.
        eng_suppress = 1'b1;
        seen0 = rsp_seen;
        run_job(3, 128'h33, 128'h44);
        wait_idle("to_idle");
        chk("to_err", err_timeout, 1'b1);
        chk("to_rise", t_err - (t_evi + 1), 16);
        chk("to_no_rsp", rsp_seen - seen0, 0);
        eng_suppress = 1'b0;
        req_valid = 4'b1010;
        n = 0;
        @(negedge clk);
        while (req_ready == '0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("to_next_grant", req_ready, 4'b0010);
        tick();
        req_valid = '0;
        wait_idle("to_next_idle");
        chk("to_err_sticky", err_timeout, 1'b1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        @(negedge clk);
        chk("err_clr", err_timeout, 1'b0);
        tick();

        // Reset while waiting on the engine.
        eng_suppress = 1'b1;
        run_job(2, 128'h77, 128'h88);
        tick();
        tick();
        reset_n = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_eng_key", eng_key, '0);
        chk("rst_eng_plain", eng_plain, '0);
        chk("rst_rsp_data", rsp_data, '0);
        tick();
        reset_n      = 1'b1;
        eng_suppress = 1'b0;
        stray_ct     = 128'h9999;
        stray        = 1'b1;
        tick();
        stray = 1'b0;
        @(negedge clk);
        chk("rst_late_valid", rsp_valid, '0);
        chk("rst_late_data", rsp_data, '0);
        tick();
        req_valid = 4'b1100;
        n = 0;
        @(negedge clk);
        while (req_ready == '0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("rst_first_grant", req_ready, 4'b0100);
        tick();
        req_valid = '0;
        wait_idle("rst_idle");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: run did not complete, got timeout, expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

endmodule
